// File: rtl/ysyx_22041752_ifu_axi_bridge_pkg.sv
// Shared constants for the instruction-side AXI bridge: AXI encodings,
// FSM state encoding and the default NOP word returned on a failed fetch.
package ysyx_22041752_ifu_axi_bridge_pkg;

   // AXI encodings used on the read-address / read-data channels
   localparam logic [1:0] RESP_OKAY  = 2'b00;
   localparam logic [1:0] BURST_INCR = 2'b01;
   localparam logic [2:0] SIZE_8B    = 3'b011;
   localparam logic [7:0] LEN_1BEAT  = 8'd0;

   // addi x0, x0, 0
   localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;

   // Bridge FSM encoding
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_AR   = 2'd1;
   localparam logic [1:0] ST_R    = 2'd2;
   localparam logic [1:0] ST_RET  = 2'd3;

endpackage

// File: rtl/ysyx_22041752_ifu_axi_bridge_if.sv
// AXI4 read-only channel bundle (AR + R) between the fetch bridge and the
// interconnect.
//   master : bridge side  (drives AR payload/valid and rready)
//   slave  : memory side  (drives arready and the R beat)
interface ysyx_22041752_ifu_axi_bridge_if #(
   parameter int ADDR_WD = 32,
   parameter int DATA_WD = 64
);
   logic               arvalid;
   logic               arready;
   logic [ADDR_WD-1:0] araddr;
   logic [3:0]         arid;
   logic [7:0]         arlen;
   logic [2:0]         arsize;
   logic [1:0]         arburst;

   logic               rvalid;
   logic               rready;
   logic [DATA_WD-1:0] rdata;
   logic [1:0]         rresp;
   logic               rlast;

   modport master (
      output arvalid, araddr, arid, arlen, arsize, arburst, rready,
      input  arready, rvalid, rdata, rresp, rlast
   );

   modport slave (
      input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
      output arready, rvalid, rdata, rresp, rlast
   );
endinterface

// File: rtl/ysyx_22041752_ifu_axi_bridge.sv
// Instruction fetch bridge: turns the fetch stage's en/ready/valid request
// into one single-beat AXI4 read, then returns the selected 32-bit word
// zero-extended on inst_rdata for one cycle. One request in flight.
// Ports:
//   clk, reset         clock, async active-low reset
//   inst_en/inst_addr  fetch request (held until inst_ready)
//   inst_ready         AR handshake completed this cycle
//   inst_valid/rdata   one-cycle response pulse with the fetched word
//   inst_err           bad RRESP or misaligned PC; word replaced by NOP
//   axi                AXI read master (AR + R channels)
module ysyx_22041752_ifu_axi_bridge
   import ysyx_22041752_ifu_axi_bridge_pkg::*;
#(
   parameter int          ADDR_WD  = 32,
   parameter int          DATA_WD  = 64,
   parameter logic [3:0]  AXI_ID   = 4'd0,
   parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               inst_en,
   input  logic [ADDR_WD-1:0] inst_addr,
   output logic               inst_ready,
   output logic               inst_valid,
   output logic [DATA_WD-1:0] inst_rdata,
   output logic               inst_err,
   ysyx_22041752_ifu_axi_bridge_if.master axi
);

   logic [1:0]         state_q, state_d;
   logic [ADDR_WD-1:0] addr_q;
   logic               sel_q;
   logic               err_q;
   logic [31:0]        word_q;

   logic               take_req;
   logic               rd_err;
   logic [31:0]        rd_word;

   // A new request is accepted from IDLE, or straight out of RET so that
   // consecutive fetches skip the idle bubble.
   assign take_req = inst_en && (state_q == ST_IDLE || state_q == ST_RET);

   assign rd_err  = (axi.rresp != RESP_OKAY) || (addr_q[1:0] != 2'b00);
   assign rd_word = rd_err ? NOP_INST
                  : (sel_q ? axi.rdata[63:32] : axi.rdata[31:0]);

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (inst_en)     state_d = ST_AR;
         ST_AR:   if (axi.arready) state_d = ST_R;
         ST_R:    if (axi.rvalid)  state_d = ST_RET;
         ST_RET:  state_d = inst_en ? ST_AR : ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         sel_q   <= 1'b0;
         err_q   <= 1'b0;
         word_q  <= '0;
      end else begin
         state_q <= state_d;
         if (take_req) begin
            addr_q <= inst_addr;
            sel_q  <= inst_addr[2];
         end
         if (state_q == ST_R && axi.rvalid) begin
            word_q <= rd_word;
            err_q  <= rd_err;
         end
      end
   end

   // All channel controls decode the state register, so they are glitch-free
   // registered outputs and fall as soon as reset asserts.
   assign axi.arvalid = (state_q == ST_AR);
   assign axi.araddr  = {addr_q[ADDR_WD-1:3], 3'b000};
   assign axi.arid    = AXI_ID;
   assign axi.arlen   = LEN_1BEAT;
   assign axi.arsize  = SIZE_8B;
   assign axi.arburst = BURST_INCR;
   assign axi.rready  = (state_q == ST_R);

   assign inst_ready = axi.arvalid && axi.arready;
   assign inst_valid = (state_q == ST_RET);
   assign inst_err   = inst_valid && err_q;
   assign inst_rdata = {{(DATA_WD-32){1'b0}}, word_q};

   // Single-beat reads only; rlast carries no information. Bit 2 of the
   // address lives on in sel_q.
   logic unused_ok;
   assign unused_ok = ^{axi.rlast, addr_q[2]};

   // The interconnect may only present a beat while we are waiting for one.
   rvalid_only_in_r: assert property (
      @(posedge clk) disable iff (!reset) axi.rvalid |-> (state_q == ST_R));

endmodule

// File: tb/tb_ysyx_22041752_ifu_axi_bridge.sv
module tb_ysyx_22041752_ifu_axi_bridge;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        inst_en = 1'b0;
   logic [31:0] inst_addr = '0;
   logic        inst_ready, inst_valid, inst_err;
   logic [63:0] inst_rdata;

   localparam logic [63:0] MEM_WORD = 64'h00000297_00000413;

   int n_chk = 0;
   int n_fail = 0;

   ysyx_22041752_ifu_axi_bridge_if #(.ADDR_WD(32), .DATA_WD(64)) bus ();

   ysyx_22041752_ifu_axi_bridge dut (
      .clk        (clk),
      .reset      (reset),
      .inst_en    (inst_en),
      .inst_addr  (inst_addr),
      .inst_ready (inst_ready),
      .inst_valid (inst_valid),
      .inst_rdata (inst_rdata),
      .inst_err   (inst_err),
      .axi        (bus.master)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   // Standard fetch with an always-ready slave; ends on the negedge of the
   // response cycle and reports what was seen there.
   task automatic run_fetch(input logic [31:0] a, input logic [63:0] d,
                            input logic [1:0] resp, output logic [31:0] ar_seen,
                            output logic vld, output logic [63:0] rd,
                            output logic err);
      inst_en = 1'b1; inst_addr = a; bus.arready = 1'b1;
      tick;
      ar_seen = bus.araddr;
      inst_en = 1'b0;
      tick;
      bus.rvalid = 1'b1; bus.rdata = d; bus.rresp = resp; bus.rlast = 1'b1;
      tick;
      bus.rvalid = 1'b0; bus.rresp = 2'b00; bus.rlast = 1'b0;
      vld = inst_valid; rd = inst_rdata; err = inst_err;
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      n_chk++; if (bus.arvalid !== 1'b0) begin n_fail++; $display("FAIL rst_arvalid: got %b want 0", bus.arvalid); end
      n_chk++; if (bus.rready !== 1'b0) begin n_fail++; $display("FAIL rst_rready: got %b want 0", bus.rready); end
      n_chk++; if (inst_valid !== 1'b0 || inst_ready !== 1'b0 || inst_err !== 1'b0) begin
         n_fail++; $display("FAIL rst_flags: got v=%b r=%b e=%b want 0", inst_valid, inst_ready, inst_err); end
      n_chk++; if (inst_rdata !== 64'h0) begin n_fail++; $display("FAIL rst_rdata: got %h want 0", inst_rdata); end
      n_chk++; if ({bus.arid, bus.arlen, bus.arsize, bus.arburst} !== {4'd0, 8'd0, 3'b011, 2'b01}) begin
         n_fail++; $display("FAIL rst_arconst: got id=%h len=%h size=%b burst=%b", bus.arid, bus.arlen, bus.arsize, bus.arburst); end
      reset = 1'b1;
      tick;
   endtask

   task automatic test_basic;
      inst_en = 1'b1; inst_addr = 32'h8000_0000; bus.arready = 1'b1;
      tick; // request sampled; AR visible one cycle later
      n_chk++; if (bus.arvalid !== 1'b1) begin n_fail++; $display("FAIL basic_arvalid: got %b want 1", bus.arvalid); end
      n_chk++; if (bus.araddr !== 32'h8000_0000) begin n_fail++; $display("FAIL basic_araddr: got %h want 80000000", bus.araddr); end
      n_chk++; if (inst_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready: got %b want 1", inst_ready); end
      inst_en = 1'b0;
      tick;
      n_chk++; if (bus.rready !== 1'b1 || bus.arvalid !== 1'b0) begin
         n_fail++; $display("FAIL basic_rphase: got rready=%b arvalid=%b want 1 0", bus.rready, bus.arvalid); end
      bus.rvalid = 1'b1; bus.rdata = MEM_WORD; bus.rresp = 2'b00;
      tick; // third edge after the request: response due now
      bus.rvalid = 1'b0;
      n_chk++; if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL basic_latency: got valid=%b want 1", inst_valid); end
      n_chk++; if (inst_rdata !== 64'h0000_0000_0000_0413) begin n_fail++; $display("FAIL basic_rdata: got %h want 413", inst_rdata); end
      n_chk++; if (inst_err !== 1'b0) begin n_fail++; $display("FAIL basic_err: got %b want 0", inst_err); end
      tick;
      n_chk++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL basic_pulse: got %b want 0", inst_valid); end
      n_chk++; if (inst_rdata !== 64'h0000_0000_0000_0413) begin n_fail++; $display("FAIL basic_hold: got %h want 413", inst_rdata); end
   endtask

   task automatic test_upper_word;
      logic [31:0] ar; logic v, e; logic [63:0] rd;
      run_fetch(32'h8000_0004, MEM_WORD, 2'b00, ar, v, rd, e);
      n_chk++; if (ar !== 32'h8000_0000) begin n_fail++; $display("FAIL upper_araddr: got %h want 80000000", ar); end
      n_chk++; if (v !== 1'b1 || rd !== 64'h0000_0000_0000_0297 || e !== 1'b0) begin
         n_fail++; $display("FAIL upper_data: got v=%b d=%h e=%b want 1 297 0", v, rd, e); end
      tick;
   endtask

   task automatic test_ar_stall;
      int vcnt;
      logic [63:0] rd;
      bus.arready = 1'b0;
      inst_en = 1'b1; inst_addr = 32'h8000_0010;
      tick;
      for (int i = 0; i < 5; i++) begin
         n_chk++; if (bus.arvalid !== 1'b1 || bus.araddr !== 32'h8000_0010 || inst_ready !== 1'b0) begin
            n_fail++; $display("FAIL stall_hold%0d: got arvalid=%b araddr=%h ready=%b", i, bus.arvalid, bus.araddr, inst_ready); end
         tick;
      end
      bus.arready = 1'b1;
      #1;
      n_chk++; if (inst_ready !== 1'b1) begin n_fail++; $display("FAIL stall_hs: got %b want 1", inst_ready); end
      inst_en = 1'b0;
      tick;
      bus.rvalid = 1'b1; bus.rdata = 64'hdead_beef_0010_0073;
      tick;
      bus.rvalid = 1'b0;
      vcnt = int'(inst_valid); rd = inst_rdata;
      for (int i = 0; i < 4; i++) begin tick; vcnt += int'(inst_valid); end
      n_chk++; if (vcnt != 1) begin n_fail++; $display("FAIL stall_pulses: got %0d want 1", vcnt); end
      n_chk++; if (rd !== 64'h0000_0000_0010_0073) begin n_fail++; $display("FAIL stall_data: got %h want 100073", rd); end
   endtask

   task automatic test_rd_error;
      logic [31:0] ar; logic v, e; logic [63:0] rd;
      run_fetch(32'h8000_0008, MEM_WORD, 2'b10, ar, v, rd, e);
      n_chk++; if (ar !== 32'h8000_0008) begin n_fail++; $display("FAIL slverr_araddr: got %h want 80000008", ar); end
      n_chk++; if (v !== 1'b1 || rd !== 64'h13 || e !== 1'b1) begin
         n_fail++; $display("FAIL slverr_nop: got v=%b d=%h e=%b want 1 13 1", v, rd, e); end
      tick;
      n_chk++; if (inst_err !== 1'b0) begin n_fail++; $display("FAIL slverr_pulse: got %b want 0", inst_err); end
      // misaligned PC with an OKAY response still yields a NOP + error
      run_fetch(32'h8000_0002, MEM_WORD, 2'b00, ar, v, rd, e);
      n_chk++; if (ar !== 32'h8000_0000) begin n_fail++; $display("FAIL misal_araddr: got %h want 80000000", ar); end
      n_chk++; if (v !== 1'b1 || rd !== 64'h13 || e !== 1'b1) begin
         n_fail++; $display("FAIL misal_nop: got v=%b d=%h e=%b want 1 13 1", v, rd, e); end
      tick;
   endtask

   task automatic test_back_to_back;
      logic [31:0] ar; logic v, e; logic [63:0] rd;
      run_fetch(32'h8000_0008, MEM_WORD, 2'b00, ar, v, rd, e);
      n_chk++; if (v !== 1'b1 || rd !== 64'h413 || e !== 1'b0) begin
         n_fail++; $display("FAIL b2b_first: got v=%b d=%h e=%b want 1 413 0", v, rd, e); end
      inst_en = 1'b1; inst_addr = 32'h8000_000C; // raised during the response cycle
      tick;
      n_chk++; if (bus.arvalid !== 1'b1 || bus.araddr !== 32'h8000_0008 || inst_valid !== 1'b0) begin
         n_fail++; $display("FAIL b2b_ar: got arvalid=%b araddr=%h valid=%b want 1 80000008 0", bus.arvalid, bus.araddr, inst_valid); end
      inst_en = 1'b0;
      tick;
      bus.rvalid = 1'b1; bus.rdata = MEM_WORD;
      tick;
      bus.rvalid = 1'b0;
      n_chk++; if (inst_valid !== 1'b1 || inst_rdata !== 64'h297) begin
         n_fail++; $display("FAIL b2b_second: got v=%b d=%h want 1 297", inst_valid, inst_rdata); end
      tick;
   endtask

   task automatic test_reset_mid;
      logic [31:0] ar; logic v, e; logic [63:0] rd;
      inst_en = 1'b1; inst_addr = 32'h8000_0004; bus.arready = 1'b1;
      tick;
      inst_en = 1'b0;
      tick;
      n_chk++; if (bus.rready !== 1'b1) begin n_fail++; $display("FAIL midrst_inr: got rready=%b want 1", bus.rready); end
      #2 reset = 1'b0;
      #1;
      n_chk++; if (bus.arvalid !== 1'b0 || bus.rready !== 1'b0 || inst_valid !== 1'b0) begin
         n_fail++; $display("FAIL midrst_async: got arvalid=%b rready=%b valid=%b want 0", bus.arvalid, bus.rready, inst_valid); end
      n_chk++; if (inst_rdata !== 64'h0) begin n_fail++; $display("FAIL midrst_rdata: got %h want 0", inst_rdata); end
      tick; tick;
      reset = 1'b1;
      tick;
      run_fetch(32'h8000_0000, MEM_WORD, 2'b00, ar, v, rd, e);
      n_chk++; if (ar !== 32'h8000_0000 || v !== 1'b1 || rd !== 64'h413 || e !== 1'b0) begin
         n_fail++; $display("FAIL midrst_recover: got ar=%h v=%b d=%h e=%b want 80000000 1 413 0", ar, v, rd, e); end
      tick;
   endtask

   initial begin
      bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0;
      bus.rresp = 2'b00; bus.rlast = 1'b0;
      test_reset;
      test_basic;
      test_upper_word;
      test_ar_stall;
      test_rd_error;
      test_back_to_back;
      test_reset_mid;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/ysyx_22041752_ifu_axi_bridge.md
Name: ysyx_22041752_ifu_axi_bridge

Overview:
- Instruction-side bus bridge directly upstream of the fetch stage.
- Converts the fetch stage's SRAM-style handshake (inst_en / inst_ready / inst_valid) into a single-beat AXI4 read transaction on the instruction master port.
- Returns the selected 32-bit word, zero-extended into the fetch data bus, one cycle after R-channel acceptance.
- One transaction in flight at a time. Read errors are flagged and replaced with a NOP.

Parameters:
- ADDR_WD, 32, fetch and AXI address width.
- DATA_WD, 64, AXI read data width and fetch data bus width (ysyx_22041752_SRAM_DATA_WD).
- AXI_ID, 4'd0, constant ARID driven on every request.
- NOP_INST, 32'h00000013, word returned on a read error.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- inst_en  in  1  fetch request; held high by the fetch stage until inst_ready.
- inst_addr  in  ADDR_WD  fetch PC; valid while inst_en is high.
- inst_ready  out  1  address accepted (AR handshake done).
- inst_valid  out  1  one-cycle pulse; inst_rdata is valid.
- inst_rdata  out  DATA_WD  {32'b0, selected instruction word}.
- inst_err  out  1  pulses with inst_valid when RRESP != OKAY or the address is misaligned.
- arvalid  out  1  AXI read-address valid.
- arready  in  1  AXI read-address ready.
- araddr  out  ADDR_WD  AXI read address, DATA_WD-aligned.
- arid  out  4  equals AXI_ID.
- arlen  out  8  constant 0.
- arsize  out  3  constant 3'b011 (8 bytes).
- arburst  out  2  constant 2'b01 (INCR).
- rvalid  in  1  AXI read-data valid.
- rready  out  1  AXI read-data ready.
- rdata  in  DATA_WD  AXI read data.
- rresp  in  2  AXI read response.
- rlast  in  1  ignored; single beat only.

Behaviour:
- Reset state (reset==0, asynchronous): state=IDLE, arvalid=0, rready=0, inst_ready=0, inst_valid=0, inst_err=0, inst_rdata=0, internal addr/sel registers=0.
- FSM states: IDLE, AR, R, RET.
- IDLE:
  - If inst_en==1, latch inst_addr into addr_q and addr_q[2] into sel_q, then go to AR.
  - arvalid is registered, so it first rises the cycle after inst_en is sampled.
- AR:
  - arvalid=1; araddr={addr_q[ADDR_WD-1:3],3'b000}; held stable until arready.
  - inst_ready = arvalid && arready, combinational, same cycle.
  - On the handshake, go to R.
- R:
  - rready=1.
  - On rvalid:
    - Register the word: sel_q ? rdata[63:32] : rdata[31:0].
    - If rresp != 2'b00 or addr_q[1:0] != 0, register NOP_INST instead and set err_q.
    - Go to RET.
- RET:
  - inst_valid=1 for exactly one cycle; inst_err=err_q; inst_rdata={32'b0, word}.
  - Then go to IDLE, or directly to AR if inst_en==1 in this cycle (latching the new inst_addr). This gives back-to-back fetches.
- inst_rdata holds its last value outside RET; the fetch stage samples it only on inst_valid.
- Minimum latency: inst_en sampled at cycle N → arvalid at N+1 → with arready at N+1 and rvalid at N+2 → inst_valid at N+3.
- inst_en is ignored in AR and R. The request is already captured; the fetch stage keeps inst_en low after inst_ready.
- Flush handling is done in the fetch stage. The bridge never drops an outstanding response; every accepted AR produces exactly one inst_valid.
- rvalid outside state R is a protocol violation. It is ignored and an assertion is flagged.
- Reset asserted mid-transaction aborts immediately; arvalid and rready drop asynchronously. The interconnect must be reset together with the bridge.

Decomposition:
- Shared package/header (ysyx_22041752_mycpu.vh):
  - AXI constants: RESP_OKAY, BURST_INCR, SIZE_8B.
  - FSM state encoding localparams.
  - NOP_INST default.
- Single module; no sub-module is warranted.
- The word-select/NOP mux stays inline.

Test Plan:
- Reset release, inst_en=1, inst_addr=0x80000000, arready=1, rvalid one cycle later with rdata=0x00000297_00000413 → araddr=0x80000000, inst_valid pulse carries 0x00000413, inst_err=0, total latency 3 cycles.
- inst_addr=0x80000004, same rdata → araddr=0x80000000, inst_rdata[31:0]=0x00000297.
- arready held low for 5 cycles → arvalid and araddr stable all 5 cycles, inst_ready high only in the handshake cycle, exactly one inst_valid afterwards.
- rresp=2'b10 on the read of 0x80000008 → inst_valid with inst_rdata[31:0]=0x00000013, inst_err=1 for one cycle.
- inst_en held high in RET with the next address 0x8000000C → arvalid rises the following cycle with araddr=0x80000008, no IDLE cycle in between.
- reset pulled low while in R (rvalid not yet seen) → arvalid=rready=inst_valid=0 immediately; after release, a new request at 0x80000000 completes normally.
